// File: rtl/drum_pkg.sv
// Shared types and constants for the drum voice scheduler: FSM state
// encoding, default geometry, and the fixed sample-ROM map per voice.
package drum_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int NUM_VOICES_DEF = 4;
    localparam int ADDR_W_DEF     = 12;
    localparam int DATA_W_DEF     = 8;

    // ROM map, index 0 in the lowest slot: clap, kick, hat, snare.
    // Regions are contiguous and fill the 4 KiB ROM exactly.
    localparam logic [NUM_VOICES_DEF-1:0][ADDR_W_DEF-1:0] VOICE_BASE = {
        12'd3218,   // snare
        12'd2618,   // hat
        12'd1118,   // kick
        12'd0       // clap
    };

    localparam logic [NUM_VOICES_DEF-1:0][ADDR_W_DEF-1:0] VOICE_LEN = {
        12'd878,    // snare
        12'd600,    // hat
        12'd1500,   // kick
        12'd1118    // clap
    };

    // Offset-binary zero for the default mix width (8 + log2(4) = 10 bits).
    localparam logic [9:0] SILENCE_DEF = 10'd512;

endpackage

// File: rtl/drum_voice_ctr.sv
// Per-voice playback state: an active flag and the sample offset within the
// voice's ROM region. start restarts at offset 0; advance steps one sample
// and retires the voice after its final sample.
module drum_voice_ctr #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start_i,
    input  logic              advance_i,
    input  logic [ADDR_W-1:0] len_i,
    output logic              active_o,
    output logic [ADDR_W-1:0] offset_o,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] ONE = 1;

    logic              active_q, active_d;
    logic [ADDR_W-1:0] offset_q, offset_d;

    assign last_o   = (offset_q == (len_i - ONE));
    assign active_o = active_q;
    assign offset_o = offset_q;

    // Next-state: start wins (it only happens in IDLE, never alongside advance).
    always_comb begin
        active_d = active_q;
        offset_d = offset_q;
        if (start_i) begin
            active_d = 1'b1;
            offset_d = '0;
        end else if (advance_i && active_q) begin
            if (last_o) begin
                active_d = 1'b0;
                offset_d = '0;
            end else begin
                offset_d = offset_q + ONE;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            active_q <= 1'b0;
            offset_q <= '0;
        end else begin
            active_q <= active_d;
            offset_q <= offset_d;
        end
    end

endmodule

// File: rtl/drum_voice_scheduler.sv
// Time-shares one synchronous sample-ROM port between the drum voices. Each
// sample_tick runs one fixed-length frame: ISSUE/CAPTURE per voice in order,
// then DONE publishes the offset-binary sum.
//
// Interface semantics: rom_rd is a one-cycle read request, rom_data is taken
// in the following cycle with no backpressure. mix_valid is a one-cycle
// strobe with no ready; mix_out holds its value until the next strobe.
module drum_voice_scheduler import drum_pkg::*; #(
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MIX_W      = DATA_W + $clog2(NUM_VOICES),
    parameter logic [NUM_VOICES-1:0][ADDR_W-1:0] VOICE_BASE_TBL = VOICE_BASE,
    parameter logic [NUM_VOICES-1:0][ADDR_W-1:0] VOICE_LEN_TBL  = VOICE_LEN
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  sample_tick,
    input  logic [NUM_VOICES-1:0] trig,
    output logic                  rom_rd,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [DATA_W-1:0]     rom_data,
    output logic [MIX_W-1:0]      mix_out,
    output logic                  mix_valid,
    output logic [NUM_VOICES-1:0] active,
    output logic                  busy,
    output logic                  overrun,
    output state_t                dbg_state
);

    localparam int VW = $clog2(NUM_VOICES);
    localparam logic [MIX_W-1:0] SILENCE  = {1'b1, {(MIX_W-1){1'b0}}};
    localparam logic [VW-1:0]    LAST_V   = VW'(NUM_VOICES - 1);

    state_t                  state_q;
    logic [VW-1:0]           v_q;
    logic signed [MIX_W-1:0] acc_q;
    logic [MIX_W-1:0]        mix_out_q;
    logic                    mix_valid_q;
    logic                    overrun_q;
    logic [NUM_VOICES-1:0]   pending_q, pending_d;
    logic [ADDR_W-1:0]       rom_addr_q;

    logic                               apply;
    logic [NUM_VOICES-1:0]              start;
    logic [NUM_VOICES-1:0]              advance;
    logic [NUM_VOICES-1:0]              last;
    logic [NUM_VOICES-1:0][ADDR_W-1:0]  offset;
    logic                               cur_active;
    logic [ADDR_W-1:0]                  cur_addr;
    logic                               issue_rd;
    logic signed [MIX_W-1:0]            sample_ext;

    // Pending triggers are folded into the voices only on the edge that opens a frame.
    assign apply = (state_q == IDLE) && sample_tick;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        assign start[g]   = apply && pending_q[g];
        assign advance[g] = (state_q == CAPTURE) && (v_q == VW'(g));

        drum_voice_ctr #(
            .ADDR_W (ADDR_W)
        ) u_ctr (
            .clk       (clk),
            .n_rst     (n_rst),
            .start_i   (start[g]),
            .advance_i (advance[g]),
            .len_i     (VOICE_LEN_TBL[g]),
            .active_o  (active[g]),
            .offset_o  (offset[g]),
            .last_o    (last[g])
        );
    end

    assign cur_active = active[v_q];
    assign cur_addr   = VOICE_BASE_TBL[v_q] + offset[v_q];
    assign issue_rd   = (state_q == ISSUE) && cur_active;
    assign sample_ext = MIX_W'($signed(rom_data));

    // Read request is decoded from registered state so it lines up with ISSUE;
    // the address register keeps the last issued address through idle slots.
    assign rom_rd    = issue_rd;
    assign rom_addr  = issue_rd ? cur_addr : rom_addr_q;
    assign mix_out   = mix_out_q;
    assign mix_valid = mix_valid_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

    // Pending set by any trigger; cleared when applied, but a trigger on the
    // applying edge survives to the next frame.
    always_comb begin
        pending_d = pending_q;
        if (apply) begin
            pending_d = '0;
        end
        pending_d = pending_d | trig;
    end

    // Frame FSM with registered mix outputs and sticky overrun.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            v_q         <= '0;
            acc_q       <= '0;
            mix_out_q   <= SILENCE;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            pending_q   <= '0;
            rom_addr_q  <= '0;
        end else begin
            pending_q   <= pending_d;
            rom_addr_q  <= rom_addr;
            mix_valid_q <= 1'b0;
            if (sample_tick && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (sample_tick) begin
                        acc_q   <= '0;
                        v_q     <= '0;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    if (cur_active) begin
                        acc_q <= acc_q + sample_ext;
                    end
                    if (v_q == LAST_V) begin
                        state_q <= DONE;
                    end else begin
                        v_q     <= v_q + 1'b1;
                        state_q <= ISSUE;
                    end
                end
                DONE: begin
                    mix_out_q   <= $unsigned(acc_q) + SILENCE;
                    mix_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drum_voice_scheduler.sv
// Directed bench for drum_voice_scheduler with voice 0 shortened to three
// samples and a behavioural synchronous ROM.
module tb_drum_voice_scheduler;
    import drum_pkg::*;

    localparam logic [3:0][11:0] TB_LEN = {12'd878, 12'd600, 12'd1500, 12'd3};

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        sample_tick = 1'b0;
    logic [3:0]  trig = 4'd0;
    logic        rom_rd;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data = 8'd0;
    logic [9:0]  mix_out;
    logic        mix_valid;
    logic [3:0]  active;
    logic        busy;
    logic        overrun;
    state_t      dbg_state;

    logic [7:0]  mem [0:4095];

    int checks = 0;
    int errors = 0;

    // Per-frame observations filled by run_frame.
    int          f_lat;
    int          f_nrd;
    int          f_nvalid;
    logic [9:0]  f_mix;
    logic [11:0] f_addr [0:3];
    logic [3:0]  f_active0;
    logic [3:0]  f_active_end;
    logic        f_busy0;

    // Clock / reset block.
    always #5 clk = ~clk;

    // Synchronous ROM: data valid the cycle after the read.
    always @(posedge clk) begin
        if (rom_rd) rom_data <= mem[rom_addr];
    end

    drum_voice_scheduler #(
        .VOICE_LEN_TBL (TB_LEN)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .sample_tick (sample_tick),
        .trig        (trig),
        .rom_rd      (rom_rd),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .mix_out     (mix_out),
        .mix_valid   (mix_valid),
        .active      (active),
        .busy        (busy),
        .overrun     (overrun),
        .dbg_state   (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_trig(input logic [3:0] m);
        @(negedge clk);
        trig = m;
        @(negedge clk);
        trig = 4'd0;
    endtask

    // One sample_tick, then observe 14 cycles. k counts cycles after the
    // sampling edge; trig_mid is pulsed at k=3, a second tick at extra_tick_at.
    task automatic run_frame(input logic [3:0] trig_mid, input int extra_tick_at);
        @(negedge clk);
        sample_tick = 1'b1;
        f_lat = -1;
        f_nrd = 0;
        f_nvalid = 0;
        f_mix = '0;
        for (int i = 0; i < 4; i++) f_addr[i] = '0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k == 0) begin
                f_active0 = active;
                f_busy0 = busy;
            end
            if (rom_rd) begin
                if (f_nrd < 4) f_addr[f_nrd] = rom_addr;
                f_nrd++;
            end
            if (mix_valid) begin
                if (f_lat < 0) begin
                    f_lat = k;
                    f_mix = mix_out;
                end
                f_nvalid++;
            end
            trig = (k == 3) ? trig_mid : 4'd0;
            sample_tick = (k == extra_tick_at);
        end
        sample_tick = 1'b0;
        trig = 4'd0;
        f_active_end = active;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_mix_out"}, 32'(mix_out), 32'd512);
        check({pfx, "_mix_valid"}, 32'(mix_valid), 32'd0);
        check({pfx, "_active"}, 32'(active), 32'd0);
        check({pfx, "_overrun"}, 32'(overrun), 32'd0);
        check({pfx, "_rom_rd"}, 32'(rom_rd), 32'd0);
        check({pfx, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 8'h00;

        // Power-on reset.
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("por");

        // Idle tick: no reads, silence after nine cycles.
        run_frame(4'd0, -1);
        check("idle_latency", 32'(f_lat), 32'd9);
        check("idle_mix", 32'(f_mix), 32'd512);
        check("idle_nrd", 32'(f_nrd), 32'd0);
        check("idle_nvalid", 32'(f_nvalid), 32'd1);
        check("idle_busy", 32'(f_busy0), 32'd1);

        // Single voice to end of sample: +16, +32, -16, then silence.
        mem[0] = 8'h10;
        mem[1] = 8'h20;
        mem[2] = 8'hF0;
        pulse_trig(4'b0001);
        run_frame(4'd0, -1);
        check("v0_f1_active", 32'(f_active0), 32'd1);
        check("v0_f1_mix", 32'(f_mix), 32'd528);
        check("v0_f1_addr", 32'(f_addr[0]), 32'd0);
        check("v0_f1_nrd", 32'(f_nrd), 32'd1);
        run_frame(4'd0, -1);
        check("v0_f2_mix", 32'(f_mix), 32'd544);
        check("v0_f2_addr", 32'(f_addr[0]), 32'd1);
        run_frame(4'd0, -1);
        check("v0_f3_mix", 32'(f_mix), 32'd496);
        check("v0_f3_addr", 32'(f_addr[0]), 32'd2);
        check("v0_f3_active_end", 32'(f_active_end), 32'd0);
        run_frame(4'd0, -1);
        check("v0_f4_mix", 32'(f_mix), 32'd512);
        check("v0_f4_nrd", 32'(f_nrd), 32'd0);

        // Retrigger while busy in frame 2 restarts at offset 0 in frame 3.
        pulse_trig(4'b0001);
        run_frame(4'd0, -1);
        check("rt_f1_addr", 32'(f_addr[0]), 32'd0);
        run_frame(4'b0001, -1);
        check("rt_f2_addr", 32'(f_addr[0]), 32'd1);
        check("rt_f2_mix", 32'(f_mix), 32'd544);
        run_frame(4'd0, -1);
        check("rt_f3_addr", 32'(f_addr[0]), 32'd0);
        check("rt_f3_mix", 32'(f_mix), 32'd528);
        check("rt_f3_nrd", 32'(f_nrd), 32'd1);

        // Two-voice mix: 127 + (-128) around silence, clap read before kick.
        mem[0] = 8'h7F;
        mem[1118] = 8'h80;
        pulse_trig(4'b0011);
        run_frame(4'd0, -1);
        check("mix2_active", 32'(f_active0), 32'd3);
        check("mix2_nrd", 32'(f_nrd), 32'd2);
        check("mix2_addr0", 32'(f_addr[0]), 32'd0);
        check("mix2_addr1", 32'(f_addr[1]), 32'd1118);
        check("mix2_mix", 32'(f_mix), 32'd511);

        // Overrun: second tick inside the frame. Voice 0 reads mem[1]=+32,
        // voice 1 reads mem[1119]=0.
        check("ovr_before", 32'(overrun), 32'd0);
        run_frame(4'd0, 3);
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_nvalid", 32'(f_nvalid), 32'd1);
        check("ovr_latency", 32'(f_lat), 32'd9);
        check("ovr_mix", 32'(f_mix), 32'd544);
        run_frame(4'd0, -1);
        check("ovr_sticky", 32'(overrun), 32'd1);
        check("ovr_f2_mix", 32'(f_mix), 32'd496);

        // Reset in the middle of a frame.
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        n_rst = 1'b0;
        #1;
        check_reset_values("mid_async");
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("mid_release");
        run_frame(4'd0, -1);
        check("post_rst_mix", 32'(f_mix), 32'd512);
        check("post_rst_latency", 32'(f_lat), 32'd9);
        check("post_rst_nrd", 32'(f_nrd), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/drum_voice_scheduler.md
Name: drum_voice_scheduler

Overview:
- Shares one synchronous sample-ROM read port between NUM_VOICES drum voices (clap, kick, hat, snare).
- On every 8 kHz sample_tick it walks all voices in fixed order, reads one sample per active voice, and sums the samples.
- Emits one offset-binary mixed sample per tick toward the PWM/DAC stage.
- Each voice has a fixed ROM region; a trigger pulse starts or restarts that voice.

Parameters:
- NUM_VOICES, 4, number of voices (power of 2, 2..8)
- ADDR_W, 12, sample ROM address width
- DATA_W, 8, ROM sample width, two's complement
- MIX_W, DATA_W+$clog2(NUM_VOICES), mixed output width

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- sample_tick  in  1  one-cycle 8 kHz strobe
- trig  in  NUM_VOICES  one-cycle per-voice start pulses
- rom_rd  out  1  ROM read enable
- rom_addr  out  ADDR_W  ROM address
- rom_data  in  DATA_W  ROM data, valid the cycle after rom_rd
- mix_out  out  MIX_W  mixed sample, offset binary
- mix_valid  out  1  one-cycle strobe, mix_out updated
- active  out  NUM_VOICES  voice playing
- busy  out  1  frame in progress (state != IDLE)
- overrun  out  1  sticky: sample_tick arrived while busy

Behaviour:
- Reset (async, n_rst=0):
  - State IDLE; all offsets 0; active=0; pending=0; acc=0.
  - rom_rd=0, rom_addr=0, mix_valid=0, overrun=0.
  - mix_out = 2^(MIX_W-1), the silence value, e.g. 512 for the defaults.
- Triggers:
  - trig[i] sets pending[i] on the same clock edge, in any state.
  - pending is applied only when the FSM is in IDLE: active[i]=1, offset[i]=0, pending[i] cleared.
  - Retrigger of a playing voice restarts it at offset 0.
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
  - IDLE, sample_tick=1: acc=0, v=0, go to ISSUE. Pending triggers are applied on that same edge, so they play in this frame.
  - ISSUE(v):
    - If active[v]: rom_rd=1, rom_addr = VOICE_BASE[v] + offset[v].
    - Otherwise rom_rd=0 and rom_addr holds its previous value.
    - Go to CAPTURE.
  - CAPTURE(v):
    - If voice v was active at ISSUE: acc += sign-extended rom_data.
    - Advance offset[v]. If offset[v] == VOICE_LEN[v]-1: clear active[v] and reset offset[v] to 0. Otherwise offset[v] += 1.
    - If v == NUM_VOICES-1, go to DONE. Otherwise v += 1 and go to ISSUE.
  - DONE: mix_out <= acc + 2^(MIX_W-1); mix_valid=1 for this cycle only; go to IDLE.
- Latency is fixed regardless of how many voices are active.
  - sample_tick sampled at edge T gives mix_valid high in cycle T+2*NUM_VOICES+1.
  - With the defaults that is T+9. A frame always lasts 2*NUM_VOICES+2 cycles including IDLE.
- Silence: if no voice is active, a frame still runs and outputs 2^(MIX_W-1).
- Arithmetic: acc is signed MIX_W. It cannot overflow, because the worst case is NUM_VOICES × (−2^(DATA_W−1)). No saturation logic.
- sample_tick while busy: ignored, and overrun is set (sticky until reset).
- trig while busy: latched in pending, applied at the next IDLE tick. A trig on the same edge as the voice's end-of-sample clear leaves pending=1, so the voice restarts next frame.
- Reset mid-frame: immediate return to reset values. The in-flight rom_data is discarded.
- active[i] is visible combinationally from registers. It goes high on the trigger-apply edge and low on the final CAPTURE edge.

Decomposition:
- Package drum_pkg holds:
  - the state_t enum (IDLE/ISSUE/CAPTURE/DONE);
  - NUM_VOICES_DEF;
  - the localparam arrays VOICE_BASE[] and VOICE_LEN[] (e.g. clap base 0, length 1118; kick base 1118; …);
  - the silence constant.
- Sub-module drum_voice_ctr, one instance per voice:
  - holds the active flag and offset counter;
  - inputs: start, advance, len;
  - outputs: active, offset, last.

Test Plan:
- Reset check: assert n_rst=0 mid-run, then release → mix_out=512, mix_valid=0, active=0, overrun=0, rom_rd=0.
- Idle tick: no triggers, one sample_tick → no rom_rd pulses; mix_valid exactly 9 cycles later with mix_out=512.
- Single voice end-of-sample: VOICE_LEN[0] overridden to 3, ROM model bytes 0x10,0x20,0xF0; trig[0], then 4 ticks → mix_out 528, 544, 496, 512; active[0] drops after the third frame.
- Two-voice mix: voice0 data 0x7F, voice1 data 0x80, both triggered → mix_out = 512+127−128 = 511; rom_addr order is base0+0 then base1+0.
- Retrigger: trig[0] during busy in frame 2 of a voice0 playback → frame 3 reads VOICE_BASE[0]+0, not +2.
- Overrun: second sample_tick 3 cycles after the first → overrun=1 and stays 1; the frame still completes with exactly one mix_valid.
